// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// fb_pkg : shared frame-buffer pixel type and screen constants
// Revision: 1.0
// ============================================================================
package fb_pkg;

  localparam int         FB_WIDTH    = 160;
  localparam int         FB_HEIGHT   = 120;
  localparam int         FB_ADDR_W   = 15;
  localparam logic [2:0] FB_BG_COLOR = 3'b000;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [2:0]           color;
  } pixel_t;

endpackage
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// ============================================================================
// pixel_fifo : synchronous FIFO of pixel_t entries with full/empty flags
// Revision: 1.0
// ============================================================================
module pixel_fifo
  import fb_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = pixel_t
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  T            mem_q [DEPTH];
  T            mem_d [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fb_pixel_writer.sv
`default_nettype none
// ============================================================================
// fb_pixel_writer : buffers the draw pixel stream and writes it to frame RAM,
// with a full-screen clear sweep. FB_DROP_COUNT_EN adds a drop counter port.
// Revision: 1.0
// ============================================================================
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int         WIDTH      = FB_WIDTH,
  parameter int         HEIGHT     = FB_HEIGHT,
  parameter int         ADDR_W     = FB_ADDR_W,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [2:0] BG_COLOR   = FB_BG_COLOR
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic [2:0]        color,
  input  logic              plot,
  output logic              ready,
  input  logic              clear_req,
  output logic              clear_done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_data,
  output logic              mem_we,
  input  logic              mem_stall
`ifdef FB_DROP_COUNT_EN
  , output logic [15:0]     drop_count
`endif
);

  localparam int            NPIX     = WIDTH * HEIGHT;
  localparam logic [ADDR_W:0] SWEEP_END = (ADDR_W+1)'(NPIX);
  localparam logic [ADDR_W:0] SWEEP_ONE = (ADDR_W+1)'(1);
  localparam logic [10:0]   X_LIM    = 11'(WIDTH);
  localparam logic [10:0]   Y_LIM    = 11'(HEIGHT);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   sweep_q, sweep_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [2:0]        mem_data_q, mem_data_d;
  logic              mem_we_q, mem_we_d;
  logic              clear_done_q, clear_done_d;

  logic              on_screen, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic              port_free;
  logic [20:0]       lin_addr;
  pixel_t            push_pix, head_pix;

  assign on_screen = ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
  assign lin_addr  = 21'(y) * 21'(WIDTH) + 21'(x);
  assign push_pix  = '{addr: FB_ADDR_W'(lin_addr), color: color};
  assign fifo_push = plot && ready && on_screen;
  assign ready     = !fifo_full;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (pixel_t)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (push_pix),
    .pop     (fifo_pop),
    .head    (head_pix),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The write register may be reloaded once its current write has completed.
  assign port_free = !mem_we_q || !mem_stall;

  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_we_d     = mem_we_q;
    clear_done_d = 1'b0;
    fifo_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          sweep_d = '0;
          if (port_free) mem_we_d = 1'b0;
        end else if (port_free) begin
          mem_we_d = !fifo_empty;
          fifo_pop = !fifo_empty;
          if (!fifo_empty) begin
            mem_addr_d = ADDR_W'(head_pix.addr);
            mem_data_d = head_pix.color;
          end
        end
      end
      ST_CLEAR: begin
        // sweep_q counts issued sweep writes; reaching the end with the port
        // free means the final address has been accepted.
        if (port_free) begin
          if (sweep_q != SWEEP_END) begin
            mem_we_d   = 1'b1;
            mem_addr_d = sweep_q[ADDR_W-1:0];
            mem_data_d = BG_COLOR;
            sweep_d    = sweep_q + SWEEP_ONE;
          end else begin
            mem_we_d     = 1'b0;
            clear_done_d = 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      sweep_q      <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_we_q     <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_we_q     <= mem_we_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_we     = mem_we_q;
  assign clear_done = clear_done_q;
  assign busy       = (state_q == ST_CLEAR) || !fifo_empty || mem_we_q;

`ifdef FB_DROP_COUNT_EN
  logic [15:0] drop_count_q, drop_count_d;

  always_comb begin
    drop_count_d = drop_count_q;
    if (plot && !ready && on_screen && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) drop_count_q <= '0;
    else          drop_count_q <= drop_count_d;
  end

  assign drop_count = drop_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fb_pixel_writer.sv
`default_nettype none
// ============================================================================
// tb_fb_pixel_writer : scoreboard bench for fb_pixel_writer
// Revision: 1.0
// ============================================================================
module tb_fb_pixel_writer;

  localparam int NPIX = 160 * 120;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic [2:0]  color = '0;
  logic        plot = 1'b0;
  logic        clear_req = 1'b0;
  logic        mem_stall = 1'b0;
  logic        ready, clear_done, busy, mem_we;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
`ifdef FB_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  always #5 clk = ~clk;

  fb_pixel_writer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .x          (x),
    .y          (y),
    .color      (color),
    .plot       (plot),
    .ready      (ready),
    .clear_req  (clear_req),
    .clear_done (clear_done),
    .busy       (busy),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .mem_stall  (mem_stall)
`ifdef FB_DROP_COUNT_EN
    , .drop_count (drop_count)
`endif
  );

  logic [17:0] exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          done_cnt = 0;
  bit          mon_en  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change only on the negedge; sampling 1 time unit later sees the
  // exact values the next posedge will act on.
  always @(negedge clk) begin
    logic [17:0] e;
    #1;
    if (reset_n) begin
      if (clear_done) done_cnt++;
      if (mon_en && mem_we && !mem_stall) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_write_addr", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_eq("wr_addr", 32'(mem_addr), 32'(e[17:3]));
          check_eq("wr_data", 32'(mem_data), 32'(e[2:0]));
        end
      end
    end
  end

  task automatic cyc(input bit p, input int px, input int py, input int c, input bit cr);
    @(negedge clk);
    plot      = p;
    x         = 10'(px);
    y         = 10'(py);
    color     = 3'(c);
    clear_req = cr;
  endtask

  task automatic push_px(input int px, input int py, input int c);
    exp_q.push_back({15'(py * 160 + px), 3'(c)});
  endtask

  task automatic push_sweep(input int n);
    for (int a = 0; a < n; a++) exp_q.push_back({15'(a), 3'b000});
  endtask

  task automatic wait_drain(input string tag, input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq(tag, 32'(ok), 32'd1);
  endtask

  // Runs until every expected write was seen; optionally stalls the RAM
  // randomly and injects one pixel part-way through.
  task automatic run_until_empty(input string tag, input int budget, input bit rand_stall,
                                 input int plot_at, input int px, input int py, input int c);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
      clear_req = 1'b0;
      mem_stall = rand_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (k == plot_at) begin
        plot = 1'b1; x = 10'(px); y = 10'(py); color = 3'(c);
        push_px(px, py, c);
      end else begin
        plot = 1'b0;
      end
    end
    mem_stall = 1'b0;
    plot      = 1'b0;
    check_eq(tag, 32'(ok), 32'd1);
  endtask

  // Stops at the negedge where the last queued write has just been observed,
  // before it can complete.
  task automatic run_until_popped(input string tag, input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      clear_req = 1'b0;
      #2;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq(tag, 32'(ok), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_we"},    32'(mem_we),     32'd0);
    check_eq({tag, "_addr"},  32'(mem_addr),   32'd0);
    check_eq({tag, "_data"},  32'(mem_data),   32'd0);
    check_eq({tag, "_done"},  32'(clear_done), 32'd0);
    check_eq({tag, "_busy"},  32'(busy),       32'd0);
    check_eq({tag, "_ready"}, 32'(ready),      32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Single pixel: visible on the write port two edges after being driven.
    cyc(1'b1, 5, 2, 5, 1'b0);
    push_px(5, 2, 5);
    cyc(1'b0, 0, 0, 0, 1'b0);
    check_eq("single_lat_we0", 32'(mem_we), 32'd0);
    check_eq("single_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("single_lat_we1", 32'(mem_we), 32'd1);
    wait_drain("single_drain", 20);
    check_eq("single_busy_low", 32'(busy), 32'd0);

    // Off-screen pixels never reach the FIFO or the RAM.
    cyc(1'b1, 160, 0, 1, 1'b0);
    cyc(1'b1, 0, 120, 2, 1'b0);
    check_eq("offscreen_busy1", 32'(busy), 32'd0);
    cyc(1'b0, 0, 0, 0, 1'b0);
    check_eq("offscreen_busy2", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
`ifdef FB_DROP_COUNT_EN
    check_eq("offscreen_drops", 32'(drop_count), 32'd0);
`endif

    // Stalled RAM: the first pixel sits in the write register, four more
    // fill the FIFO, and the sixth sees ready=0 and is dropped.
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 10 + i, 3, i + 1, 1'b0);
      mem_stall = 1'b1;
      check_eq("stall_ready", 32'(ready), 32'(i < 5));
      if (i < 5) push_px(10 + i, 3, i + 1);
    end
    cyc(1'b0, 0, 0, 0, 1'b0);
    check_eq("stall_full", 32'(ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_hold_addr", 32'(mem_addr), 32'd490);
      check_eq("stall_hold_we", 32'(mem_we), 32'd1);
    end
`ifdef FB_DROP_COUNT_EN
    check_eq("stall_drops", 32'(drop_count), 32'd1);
`endif
    @(negedge clk);
    mem_stall = 1'b0;
    wait_drain("stall_drain", 50);

    // Clear sweep under random stalls with a pixel plotted mid-sweep.
    cyc(1'b0, 0, 0, 0, 1'b1);
    push_sweep(NPIX);
    run_until_empty("clear_finish", 30000, 1'b1, 3000, 7, 1, 6);
    check_eq("clear_done_cnt1", 32'(done_cnt), 32'd1);

    // Simultaneous clear and plot: the pixel is written after the sweep.
    cyc(1'b1, 0, 0, 7, 1'b1);
    push_sweep(NPIX);
    push_px(0, 0, 7);
    run_until_empty("clr_plot_finish", 20000, 1'b0, -1, 0, 0, 0);
    check_eq("clear_done_cnt2", 32'(done_cnt), 32'd2);

    // Asynchronous reset while the sweep presents address 100.
    cyc(1'b0, 0, 0, 0, 1'b1);
    push_sweep(101);
    run_until_popped("abort_reach100", 500);
    check_eq("abort_at_addr", 32'(mem_addr), 32'd100);
    reset_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("abort_no_done", 32'(done_cnt), 32'd2);

    // A fresh clear restarts at address 0.
    cyc(1'b0, 0, 0, 0, 1'b1);
    push_sweep(200);
    run_until_popped("restart_200", 1000);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("restart_no_done", 32'(done_cnt), 32'd2);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
